// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue
// Brief    : Circular instruction/PC FIFO between fetcher and decoder with
//            show-ahead head, single-cycle flush and global rdy stall.
// Revision : 1.0 - initial release
// ============================================================================
module inst_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              IF_valid,
    input  logic [31:0]       IF_inst,
    input  logic [31:0]       IF_pc,
    output logic              IF_queue_is_full,
    input  logic              ID_enable,
    output logic              ID_queue_is_empty,
    output logic [31:0]       ID_inst,
    output logic [31:0]       ID_pc,
    input  logic              ROB_clear
);

    localparam logic [ADDR_W:0]   c_full_count = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_cnt_one    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one    = ADDR_W'(1);

    logic [31:0]       r_inst_mem [0:DEPTH-1];
    logic [31:0]       r_pc_mem   [0:DEPTH-1];
    logic [ADDR_W-1:0] r_head;
    logic [ADDR_W-1:0] r_tail;
    logic [ADDR_W:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_wr_en;

    // Full/empty come from the count alone; head == tail is ambiguous.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_count);

    assign w_push  = rdy & IF_valid & ~w_full;
    assign w_pop   = rdy & ID_enable & ~w_empty;
    assign w_wr_en = w_push & ~ROB_clear & ~rst;

    assign IF_queue_is_full  = w_full;
    assign ID_queue_is_empty = w_empty;
    assign ID_inst           = w_empty ? 32'h0 : r_inst_mem[r_head];
    assign ID_pc             = w_empty ? 32'h0 : r_pc_mem[r_head];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_inst_mem[r_tail] <= IF_inst;
            r_pc_mem[r_tail]   <= IF_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (ROB_clear) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + c_ptr_one;
                end
                if (w_pop) begin
                    r_head <= r_head + c_ptr_one;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_cnt_one;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_cnt_one;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/inst_queue.md
# inst_queue

Circular instruction FIFO between the instruction fetcher and the decoder. The fetcher pushes one (inst, pc) pair per cycle. The decoder sees the head entry show-ahead and pops it by asserting its enable in the same cycle it consumes the entry. A flush from the ROB on branch misprediction empties the queue in one cycle.

## Interface
- DEPTH, 16, number of entries; must be a power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); head/tail pointer width. Occupancy count is ADDR_W+1 bits.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global ready; when low, all state holds.
- IF_valid  in  1  push request from fetcher.
- IF_inst  in  32  instruction to push.
- IF_pc  in  32  PC of that instruction.
- IF_queue_is_full  out  1  high when count == DEPTH.
- ID_enable  in  1  pop request from decoder.
- ID_queue_is_empty  out  1  high (`IQEmpty`) when count == 0.
- ID_inst  out  32  head instruction; 0 when empty.
- ID_pc  out  32  head PC; 0 when empty.
- ROB_clear  in  1  flush on misprediction.

## Operation
- Storage: two DEPTH-entry arrays (inst, pc); head pointer, tail pointer, count.
- Flags and outputs are combinational from registered state only:
  - empty = (count == 0); full = (count == DEPTH).
  - ID_inst/ID_pc = storage[head] when not empty, else 0.
- Push accepted: rdy & IF_valid & !full. Writes storage[tail]; tail <= tail+1 mod DEPTH.
- Pop accepted: rdy & ID_enable & !empty. head <= head+1 mod DEPTH.
- count <= count + push - pop. A simultaneous push and pop leaves count unchanged.
- Full is evaluated on current state. A push while full is dropped even if a pop occurs the same cycle. The fetcher must hold IF_inst/IF_pc and retry.
- Pop while empty is ignored. There is no push-to-pop bypass: an entry pushed into an empty queue becomes visible on the next cycle.
- ROB_clear (when rdy): head <= 0, tail <= 0, count <= 0. It overrides any push or pop that cycle; both are discarded. Storage contents are not cleared.
- rst: head = tail = count = 0 regardless of rdy. rst has priority over ROB_clear, push and pop.
- rdy low: no pointer, count or storage change. Outputs keep reflecting the held state.
- Pointer wrap: pointers increment modulo DEPTH naturally. Full versus empty is distinguished only by count, never by pointer equality.

## Timing
- Reset values after a cycle with rst high:
  - ID_queue_is_empty = 1, IF_queue_is_full = 0.
  - ID_inst = 0, ID_pc = 0.
- Push-to-visible latency: 1 cycle. An entry pushed at edge N appears on ID_inst/ID_pc after edge N and can be popped in cycle N+1.
- Pop: the decoder samples ID_inst/ID_pc and asserts ID_enable in the same cycle. The next entry (or 0 if now empty) is presented after the edge.
- Flush: after the edge with ROB_clear, empty = 1 and full = 0. A push in the following cycle is accepted normally.
- Throughput: 1 push and 1 pop per cycle sustained when 0 < count < DEPTH.
- Flag timing:
  - full deasserts one cycle after the first pop from a full queue.
  - empty deasserts one cycle after the first push into an empty queue.

## Test plan
- **Reset and fill:**
  - Reset, then push pc = 0x0, 0x4, … 0x3C with inst = 0x00000013 + pc in consecutive cycles, no pops.
  - Expect: empty drops after the first edge and ID_pc = 0x0. full rises after the 16th push. A 17th push (pc = 0x40) is dropped.
- **Drain order:**
  - From full, hold ID_enable for 16 cycles.
  - Expect: ID_pc sequence 0x0 … 0x3C in order. empty = 1 and ID_inst = 0 after the last pop. A further pop leaves count at 0.
- **Simultaneous push/pop and wrap:**
  - With count = 3, push and pop every cycle for 40 cycles.
  - Expect: count stays 3. Output PCs equal the input PCs delayed by 3 pops through multiple pointer wraps. Push+pop at full: pop happens, push is dropped, count = 15.
- **Flush:**
  - With count = 7, assert ROB_clear together with IF_valid and ID_enable.
  - Expect: next cycle empty = 1, ID_pc = 0, and the pushed entry is absent. Pushing pc = 0x100 then presents 0x100 at the head.
- **rdy stall:**
  - With count = 5, drop rdy for 4 cycles while driving IF_valid, ID_enable and ROB_clear.
  - Expect: count, head entry and flags unchanged. Normal operation resumes when rdy returns.
- **Reset mid-operation:**
  - Assert rst with count = 9 and push+pop active.
  - Expect: after the edge empty = 1, full = 0, ID_inst = ID_pc = 0.
